// File: rtl/actifunction_pipe_if.sv
// -----------------------------------------------------------------------------
// actifunction_pipe_if
// Stream interface of the activation pipe: one input beat channel and one
// output beat channel, each with a valid/ready handshake.
//   in_valid / in_ready / in_mode / in_data   : beat from the MAC accumulators
//   out_valid / out_ready / out_data          : beat to the layer output buffer
// Modports:
//   master : producer of input beats and consumer of output beats
//   slave  : the activation pipe itself
// -----------------------------------------------------------------------------
interface actifunction_pipe_if #(
   parameter int LANES = 32'sd1,
   parameter int IN_W  = 32'sd24,
   parameter int OUT_W = 32'sd16
);
   logic                   in_valid;
   logic                   in_ready;
   logic                   in_mode;
   logic [LANES*IN_W-1:0]  in_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [LANES*OUT_W-1:0] out_data;

   modport master (
      output in_valid, in_mode, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_mode, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/actifunction_pipe.sv
// -----------------------------------------------------------------------------
// actifunction_pipe
// Two-stage pipelined activation unit for LANES signed fixed-point values per
// beat. Each beat selects piecewise-linear sigmoid (in_mode=0) or saturating
// ReLU (in_mode=1); the mode travels with its beat.
//   S1 : registers data and mode, decodes the sigmoid region of every lane
//   S2 : registers the computed, clamped result (drives out_data/out_valid)
// Full backpressure: S2 loads when empty or out_ready; S1 loads when empty or
// S2 loads; in_ready = !s1_valid || s2_load (forced low while rst is high).
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset, clears both stages
//   bus       : actifunction_pipe_if.slave (input and output beat channels)
//   sat_clr   : synchronous clear of sat_count
//   sat_count : number of saturating lanes seen at the output
// Optional feature macro: ACTI_SAT_CNT_EN. When defined, sat_count counts
// saturating lanes of every beat accepted downstream (saturating at 0xFFFF,
// sat_clr has priority). When undefined, sat_count is tied to zero and no
// counter logic exists.
// -----------------------------------------------------------------------------
module actifunction_pipe #(
   parameter int LANES    = 32'sd1,
   parameter int IN_W     = 32'sd24,
   parameter int IN_FRAC  = 32'sd20,
   parameter int OUT_W    = 32'sd16,
   parameter int OUT_FRAC = 32'sd15
) (
   input  logic                clk,
   input  logic                rst,
   actifunction_pipe_if.slave  bus,
   input  logic                sat_clr,
   output logic [15:0]         sat_count
);

   // Sigmoid sums are formed at OUT_W+2 bits; EXT_W is wide enough to hold
   // both the sign-extended input and any shifted ReLU value before clamping.
   localparam int SUM_W = OUT_W + 32'sd2;
   localparam int EXT_W = IN_W + SUM_W;
   localparam int SHIFT = IN_FRAC - OUT_FRAC;

   localparam logic signed [IN_W:0]      POS_ONE_C   = (IN_W+1)'(64'sd1 <<< IN_FRAC);
   localparam logic signed [IN_W:0]      NEG_ONE_C   = -POS_ONE_C;
   localparam logic signed [IN_W:0]      POS_THREE_C = (IN_W+1)'(64'sd3 <<< IN_FRAC);
   localparam logic signed [IN_W:0]      NEG_THREE_C = -POS_THREE_C;
   localparam logic signed [SUM_W-1:0]   HALF_C      = SUM_W'(64'sd1 <<< (OUT_FRAC - 32'sd1));
   localparam logic signed [SUM_W-1:0]   P625_C      = SUM_W'(64'sd5 <<< (OUT_FRAC - 32'sd3));
   localparam logic signed [SUM_W-1:0]   P375_C      = SUM_W'(64'sd3 <<< (OUT_FRAC - 32'sd3));
   localparam logic [OUT_W-1:0]          YMAX_C      = OUT_W'((64'sd1 <<< (OUT_W - 32'sd1)) - 64'sd1);
   localparam logic signed [EXT_W-1:0]   YMAX_EXT_C  = EXT_W'(YMAX_C);

   // Sigmoid region of one lane; the mid regions differ only in their offset.
   typedef enum logic [2:0] {
      RG_LIN  = 3'd0,   // |x| <= 1.0
      RG_MIDP = 3'd1,   // 1.0 < x < 3.0
      RG_MIDN = 3'd2,   // -3.0 < x < -1.0
      RG_SATP = 3'd3,   // x >= 3.0
      RG_SATN = 3'd4    // x <= -3.0
   } region_e;

   function automatic region_e decode_region(input logic signed [IN_W-1:0] x);
      logic signed [IN_W:0] xe;
      region_e              rg;
      xe = {x[IN_W-1], x};
      if (xe >= POS_THREE_C) begin
         rg = RG_SATP;
      end else if (xe <= NEG_THREE_C) begin
         rg = RG_SATN;
      end else if (xe > POS_ONE_C) begin
         rg = RG_MIDP;
      end else if (xe < NEG_ONE_C) begin
         rg = RG_MIDN;
      end else begin
         rg = RG_LIN;
      end
      return rg;
   endfunction

   function automatic logic [OUT_W-1:0] clamp_out(input logic signed [EXT_W-1:0] v);
      logic [OUT_W-1:0] y;
      if (v[EXT_W-1]) begin
         y = {OUT_W{1'b0}};
      end else if (v > YMAX_EXT_C) begin
         y = YMAX_C;
      end else begin
         y = v[OUT_W-1:0];
      end
      return y;
   endfunction

   // Shifts by SHIFT+2 / SHIFT+3 realise x/4 and x/8 re-aligned to OUT_FRAC
   // (arithmetic shift, so rounding is toward minus infinity).
   function automatic logic [OUT_W-1:0] compute_lane(
      input logic signed [IN_W-1:0] x,
      input logic                   mode,
      input region_e                rg
   );
      logic signed [EXT_W-1:0] xe;
      logic signed [SUM_W-1:0] sum;
      logic signed [EXT_W-1:0] pre;
      xe = EXT_W'(x);
      case (rg)
         RG_LIN:  sum = SUM_W'(xe >>> (SHIFT + 32'sd2)) + HALF_C;
         RG_MIDP: sum = SUM_W'(xe >>> (SHIFT + 32'sd3)) + P625_C;
         RG_MIDN: sum = SUM_W'(xe >>> (SHIFT + 32'sd3)) + P375_C;
         RG_SATP: sum = SUM_W'(YMAX_C);
         RG_SATN: sum = {SUM_W{1'b0}};
         default: sum = {SUM_W{1'b0}};
      endcase
      if (mode) begin
         pre = xe >>> SHIFT;
      end else begin
         pre = EXT_W'(sum);
      end
      return clamp_out(pre);
   endfunction

   logic                   s1_valid_r;
   logic                   s1_mode_r;
   logic [LANES*IN_W-1:0]  s1_data_r;
   region_e                s1_region_r [LANES];
   logic                   s2_valid_r;
   logic [LANES*OUT_W-1:0] s2_data_r;

   logic                   s2_load_s;
   logic                   s1_load_s;
   logic                   in_ready_s;
   region_e                region_s [LANES];
   logic [LANES*OUT_W-1:0] s2_next_s;

   // Handshake: a stage may take a new beat when empty or when its content moves on.
   always_comb begin
      s2_load_s  = !s2_valid_r || bus.out_ready;
      s1_load_s  = !s1_valid_r || s2_load_s;
      in_ready_s = !rst && s1_load_s;
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = s2_valid_r;
   assign bus.out_data  = s2_data_r;

   // Region decode of the incoming beat, stored alongside it in S1.
   always_comb begin
      for (int i = 32'sd0; i < LANES; i++) begin
         region_s[i] = decode_region(bus.in_data[i*IN_W +: IN_W]);
      end
   end

   // S1 register: accepted beat, its mode and per-lane region.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         s1_mode_r  <= 1'b0;
         s1_data_r  <= {(LANES*IN_W){1'b0}};
         for (int i = 32'sd0; i < LANES; i++) begin
            s1_region_r[i] <= RG_LIN;
         end
      end else if (s1_load_s) begin
         s1_valid_r <= bus.in_valid;
         if (bus.in_valid) begin
            s1_mode_r <= bus.in_mode;
            s1_data_r <= bus.in_data;
            for (int i = 32'sd0; i < LANES; i++) begin
               s1_region_r[i] <= region_s[i];
            end
         end
      end
   end

   // Per-lane clamped result of the beat currently held in S1.
   always_comb begin
      s2_next_s = {(LANES*OUT_W){1'b0}};
      for (int i = 32'sd0; i < LANES; i++) begin
         s2_next_s[i*OUT_W +: OUT_W] =
            compute_lane(s1_data_r[i*IN_W +: IN_W], s1_mode_r, s1_region_r[i]);
      end
   end

   // S2 register: output beat; holds its content while stalled downstream.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid_r <= 1'b0;
         s2_data_r  <= {(LANES*OUT_W){1'b0}};
      end else if (s2_load_s) begin
         s2_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            s2_data_r <= s2_next_s;
         end
      end
   end

`ifdef ACTI_SAT_CNT_EN
   logic [LANES-1:0] sat_next_s;
   logic [LANES-1:0] s2_sat_r;
   logic [15:0]      sat_count_r;
   logic [16:0]      sat_sum_s;

   // A lane saturates when its result sits on either clamp bound; the
   // |x| >= 3.0 sigmoid regions always land on a bound.
   always_comb begin
      sat_next_s = {LANES{1'b0}};
      for (int i = 32'sd0; i < LANES; i++) begin
         sat_next_s[i] = (s2_next_s[i*OUT_W +: OUT_W] == {OUT_W{1'b0}}) ||
                         (s2_next_s[i*OUT_W +: OUT_W] == YMAX_C);
      end
   end

   // Saturation flags travel in S2 next to the result they describe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_sat_r <= {LANES{1'b0}};
      end else if (s2_load_s && s1_valid_r) begin
         s2_sat_r <= sat_next_s;
      end
   end

   // Counter value plus the number of saturating lanes in the S2 beat.
   always_comb begin
      sat_sum_s = {1'b0, sat_count_r};
      for (int i = 32'sd0; i < LANES; i++) begin
         sat_sum_s = sat_sum_s + {16'd0, s2_sat_r[i]};
      end
   end

   // Saturation counter: clear wins, counts only beats taken downstream, sticks at max.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_count_r <= 16'h0000;
      end else if (sat_clr) begin
         sat_count_r <= 16'h0000;
      end else if (s2_valid_r && bus.out_ready) begin
         sat_count_r <= sat_sum_s[16] ? 16'hFFFF : sat_sum_s[15:0];
      end
   end

   assign sat_count = sat_count_r;
`else
   logic unused_sat_clr_s;
   assign unused_sat_clr_s = sat_clr;
   assign sat_count        = 16'h0000;
`endif

endmodule

// File: tb/tb_actifunction_pipe.sv
// -----------------------------------------------------------------------------
// tb_actifunction_pipe
// Self-checking bench for actifunction_pipe (LANES=4). A behavioural model
// computes every lane result from the activation rules with integer
// arithmetic; a queue of expected beats tracks in-flight data, latency and
// the saturation count. One compare process checks the DUT on every falling
// edge; directed, backpressure, random and mid-stream reset phases drive it.
// -----------------------------------------------------------------------------
module tb_actifunction_pipe;
   localparam int LANES    = 4;
   localparam int IN_W     = 24;
   localparam int IN_FRAC  = 20;
   localparam int OUT_W    = 16;
   localparam int OUT_FRAC = 15;
   localparam int ONE      = 1 << IN_FRAC;
   localparam int OSC      = 1 << OUT_FRAC;
   localparam int YMAX     = (1 << (OUT_W - 1)) - 1;
`ifdef ACTI_SAT_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   typedef struct {
      int                     cyc;
      logic [LANES*OUT_W-1:0] y;
      int                     nsat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        sat_clr;
   logic [15:0] sat_count;
   int          checks   = 0;
   int          failures = 0;
   int          rdy_mode = 0;   // 0 always ready, 1 pattern 1,0,0,1, 2 random, 3 never
   int          cyc      = 0;
   exp_t        q[$];
   int          mcnt     = 0;

   actifunction_pipe_if #(.LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W)) bus_if ();

   actifunction_pipe #(
      .LANES(LANES), .IN_W(IN_W), .IN_FRAC(IN_FRAC), .OUT_W(OUT_W), .OUT_FRAC(OUT_FRAC)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus_if.slave), .sat_clr(sat_clr), .sat_count(sat_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int fdiv(input int x, input int d);
      int qt;
      qt = x / d;
      if ((x % d != 0) && (x < 0)) qt = qt - 1;
      return qt;
   endfunction

   function automatic int clampy(input int v);
      if (v < 0) return 0;
      if (v > YMAX) return YMAX;
      return v;
   endfunction

   function automatic int model_y(input int x, input bit relu);
      int sc;
      sc = ONE / OSC;               // input LSBs per output LSB
      if (relu) return clampy(fdiv(x, sc));
      if (x >= 3 * ONE) return YMAX;
      if (x <= -3 * ONE) return 0;
      if (x >= -ONE && x <= ONE) return clampy(OSC / 2 + fdiv(x, 4 * sc));
      if (x > 0) return clampy((5 * OSC) / 8 + fdiv(x, 8 * sc));
      return clampy((3 * OSC) / 8 + fdiv(x, 8 * sc));
   endfunction

   function automatic int sx(input logic [IN_W-1:0] v);
      return int'($signed(v));
   endfunction

   function automatic exp_t make_exp(input logic m, input logic [LANES*IN_W-1:0] d, input int c);
      exp_t e;
      e.cyc  = c;
      e.nsat = 0;
      e.y    = '0;
      for (int i = 0; i < LANES; i++) begin
         int yv;
         yv = model_y(sx(d[i*IN_W +: IN_W]), m);
         e.y[i*OUT_W +: OUT_W] = 16'(yv);
         if (yv == 0 || yv == YMAX) e.nsat++;
      end
      return e;
   endfunction

   // ---------------- compare process ----------------
   initial begin
      logic                   prev_stall;
      logic [LANES*OUT_W-1:0] prev_data;
      bit                     exp_v;
      prev_stall = 1'b0;
      prev_data  = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            chk("rst_out_valid", bus_if.out_valid, 0);
            chk("rst_in_ready", bus_if.in_ready, 0);
            q.delete();
            mcnt       = 0;
            prev_stall = 1'b0;
         end else begin
            chk("in_ready", bus_if.in_ready, !(q.size() == 2 && !bus_if.out_ready));
            exp_v = (q.size() > 0) && (cyc >= q[0].cyc + 2);
            chk("out_valid", bus_if.out_valid, exp_v);
            if (exp_v) chk("out_data", bus_if.out_data, q[0].y);
            if (prev_stall) chk("stall_hold", bus_if.out_data, prev_data);
            chk("sat_count", sat_count, CNT_EN ? mcnt : 0);
            if (sat_clr) begin
               mcnt = 0;
               if (exp_v && bus_if.out_ready) void'(q.pop_front());
            end else if (exp_v && bus_if.out_ready) begin
               mcnt = (mcnt + q[0].nsat > 65535) ? 65535 : mcnt + q[0].nsat;
               void'(q.pop_front());
            end
            if (bus_if.in_valid && bus_if.in_ready)
               q.push_back(make_exp(bus_if.in_mode, bus_if.in_data, cyc));
            prev_stall = bus_if.out_valid && !bus_if.out_ready;
            prev_data  = bus_if.out_data;
         end
      end
   end

   // ---------------- out_ready driver ----------------
   initial begin
      bus_if.out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       bus_if.out_ready = 1'b1;
            1:       bus_if.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            2:       bus_if.out_ready = ($urandom_range(0, 2) != 0);
            default: bus_if.out_ready = 1'b0;
         endcase
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic m, input logic [LANES*IN_W-1:0] d);
      bit ok;
      ok = 1'b0;
      bus_if.in_valid = 1'b1;
      bus_if.in_mode  = m;
      bus_if.in_data  = d;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (bus_if.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      chk("accept_timeout", ok, 1);
      @(posedge clk);
      #1;
      bus_if.in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      rdy_mode = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (q.size() == 0) break;
      end
      chk("drain_empty", q.size(), 0);
      idle(2);
   endtask

   function automatic logic [LANES*IN_W-1:0] beat1(input logic [IN_W-1:0] x);
      logic [LANES*IN_W-1:0] d;
      d = '0;
      d[IN_W-1:0] = x;
      return d;
   endfunction

   function automatic logic [IN_W-1:0] rand_x();
      int v;
      case ($urandom_range(0, 5))
         0: v = int'($urandom);
         1: begin
            case ($urandom_range(0, 6))
               0: v = ONE;
               1: v = -ONE;
               2: v = 3 * ONE;
               3: v = -3 * ONE;
               4: v = 3 * ONE - 1;
               5: v = -3 * ONE + 1;
               default: v = 0;
            endcase
         end
         default: v = int'($urandom_range(0, 8 * ONE)) - 4 * ONE;
      endcase
      return v[IN_W-1:0];
   endfunction

   function automatic logic [LANES*IN_W-1:0] rand_beat();
      logic [LANES*IN_W-1:0] d;
      for (int i = 0; i < LANES; i++) d[i*IN_W +: IN_W] = rand_x();
      return d;
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      logic [IN_W-1:0] t1 [5];
      logic [IN_W-1:0] t2 [4];
      logic [IN_W-1:0] t3 [3];
      rst              = 1'b1;
      sat_clr          = 1'b0;
      bus_if.in_valid  = 1'b0;
      bus_if.in_mode   = 1'b0;
      bus_if.in_data   = '0;
      t1 = '{24'h000000, 24'h100000, 24'hF00000, 24'h200000, 24'hE00000};
      t2 = '{24'h300000, 24'hD00000, 24'h400000, 24'h2FFFFF};
      t3 = '{24'h080000, 24'hF80000, 24'h200000};

      // model pins (hand-computed)
      chk("pin_sig_0",      model_y(sx(24'h000000), 0), 16'h4000);
      chk("pin_sig_p1",     model_y(sx(24'h100000), 0), 16'h6000);
      chk("pin_sig_m1",     model_y(sx(24'hF00000), 0), 16'h2000);
      chk("pin_sig_p2",     model_y(sx(24'h200000), 0), 16'h7000);
      chk("pin_sig_m2",     model_y(sx(24'hE00000), 0), 16'h1000);
      chk("pin_sig_p3",     model_y(sx(24'h300000), 0), 16'h7FFF);
      chk("pin_sig_m3",     model_y(sx(24'hD00000), 0), 16'h0000);
      chk("pin_sig_p4",     model_y(sx(24'h400000), 0), 16'h7FFF);
      chk("pin_sig_2fffff", model_y(sx(24'h2FFFFF), 0), 16'h7FFF);
      chk("pin_relu_half",  model_y(sx(24'h080000), 1), 16'h4000);
      chk("pin_relu_neg",   model_y(sx(24'hF80000), 1), 16'h0000);
      chk("pin_relu_big",   model_y(sx(24'h200000), 1), 16'h7FFF);

      idle(3);
      rst = 1'b0;
      #1;
      chk("reset_in_ready", bus_if.in_ready, 1);
      chk("reset_out_valid", bus_if.out_valid, 0);
      chk("reset_out_data", bus_if.out_data, 0);
      chk("reset_sat_count", sat_count, 0);
      idle(1);

      // sigmoid, back-to-back
      foreach (t1[i]) send(1'b0, beat1(t1[i]));
      drain();

      // sigmoid boundaries, counted from a cleared counter
      sat_clr = 1'b1;
      idle(1);
      sat_clr = 1'b0;
      foreach (t2[i]) send(1'b0, beat1(t2[i]));
      drain();
      chk("sat_count_boundary", sat_count, CNT_EN ? 4 : 0);

      // ReLU
      foreach (t3[i]) send(1'b1, beat1(t3[i]));
      drain();

      // four lanes with distinct values, both modes
      send(1'b1, {24'h2FFFFF, 24'hF80000, 24'h080000, 24'h100000});
      send(1'b0, {24'h2FFFFF, 24'hF80000, 24'h080000, 24'h100000});
      drain();

      // backpressure: alternating modes, out_ready 1,0,0,1
      rdy_mode = 1;
      for (int n = 0; n < 6; n++) send(n[0], rand_beat());
      drain();

      // random traffic, random backpressure, occasional counter clears
      rdy_mode = 2;
      for (int n = 0; n < 400; n++) begin
         sat_clr = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 3) != 0) send($urandom_range(0, 1), rand_beat());
         else idle(1);
      end
      sat_clr = 1'b0;
      drain();

      // reset with two beats in flight
      rdy_mode = 3;
      idle(1);
      send(1'b0, rand_beat());
      send(1'b1, rand_beat());
      chk("inflight_out_valid", bus_if.out_valid, 1);
      rst = 1'b1;
      #1;
      chk("async_out_valid", bus_if.out_valid, 0);
      chk("async_in_ready", bus_if.in_ready, 0);
      idle(2);
      rst = 1'b0;
      rdy_mode = 0;
      #1;
      chk("post_rst_sat_count", sat_count, 0);
      idle(8);
      send(1'b0, beat1(24'h100000));
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
